multi_dual_buffer: RTL and testbench

Parametrised multi-channel double-buffered capture block for the ADC front end, sitting between the synchronised ADC sample path and the MCU parallel-bus slave. Channels are captured in lock-step into a back buffer around a configurable trigger point (pre-trigger ring), then swapped to a front buffer that the MCU reads over an address-latched register interface. It adds selectable trigger mode and source, pre-trigger depth, lock/unlock handshake, overrun flag and frame counter.

---
 rtl/multi_dual_buffer.sv | 196 +++++++++++++++++++
 tb/tb_multi_dual_buffer.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/multi_dual_buffer.sv
// Multi-channel double-buffered ADC capture with a pre-trigger ring, trigger modes,
// lock/overrun handshake and an address-latched MCU register/sample window.
module multi_dual_buffer #(
   parameter int BUS_W  = 16,
   parameter int ADC_W  = 12,
   parameter int CH_NUM = 2,
   parameter int DEPTH  = 1024
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    bus_en,
   input  logic                    addr_we,
   input  logic                    reg_we,
   input  logic                    rd_req,
   input  logic [BUS_W-1:0]        bus_din,
   output logic [BUS_W-1:0]        bus_dout,
   input  logic                    sample_stb,
   input  logic [CH_NUM*ADC_W-1:0] adc_data,
   input  logic [CH_NUM-1:0]       trig_in,
   input  logic                    stable,
   output logic                    frame_ready
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   typedef enum logic [2:0] {S_IDLE, S_ARMED, S_WAIT, S_POST, S_SWAP} state_t;

   state_t            r_state;
   logic [BUS_W-1:0]  r_addr;
   logic [BUS_W-1:0]  r_dout;
   logic              r_arm;
   logic [1:0]        r_mode;
   logic              r_lock;
   logic [AW-1:0]     r_pre;
   logic [1:0]        r_tsel;
   logic              r_front;
   logic [AW-1:0]     r_start;
   logic [AW-1:0]     r_wptr;
   logic [PW-1:0]     r_cnt;
   logic              r_ready;
   logic              r_overrun;
   logic [15:0]       r_fcnt;
   logic              r_trig_prev;
   logic [ADC_W-1:0]  r_mem [CH_NUM][2*DEPTH];

   logic              w_reg_wr, w_ctrl_wr, w_lock_rise, w_lock_block;
   logic              w_trig_cur, w_trig, w_cap;
   logic [PW-1:0]     w_cnt_inc, w_post_len;
   logic [AW-1:0]     w_ridx;
   logic [BUS_W-1:0]  w_win, w_reg, w_rdata;
   logic              w_unused;

   assign w_reg_wr     = bus_en & reg_we & r_addr[14];
   assign w_ctrl_wr    = w_reg_wr && (r_addr[13:0] == 14'h1);
   assign w_lock_rise  = w_ctrl_wr & bus_din[0] & ~r_lock;
   // A lock write landing on the swap edge must still block the swap.
   assign w_lock_block = r_lock | (w_ctrl_wr & bus_din[0]);
   assign w_cnt_inc    = r_cnt + PW'(1);
   assign w_post_len   = PW'(DEPTH) - {1'b0, r_pre};
   assign w_cap        = sample_stb & stable &
                         ((r_state == S_ARMED) | (r_state == S_WAIT) | (r_state == S_POST));
   assign w_unused     = r_addr[BUS_W-1];

   always_comb begin
      w_trig_cur = 1'b0;
      for (int c = 0; c < CH_NUM; c++)
         if (int'(r_tsel) == c) w_trig_cur = trig_in[c];
   end

   always_comb begin
      case (r_mode)
         2'b00:   w_trig = 1'b1;
         2'b01:   w_trig = w_trig_cur & ~r_trig_prev;
         2'b10:   w_trig = ~w_trig_cur & r_trig_prev;
         default: w_trig = w_trig_cur ^ r_trig_prev;
      endcase
   end

   // Sample window: front bank, rotated so offset 0 is the oldest sample.
   assign w_ridx = r_start + r_addr[AW-1:0];
   always_comb begin
      w_win = '1;
      for (int c = 0; c < CH_NUM; c++)
         if (int'(r_addr[AW+1:AW]) == c) w_win = BUS_W'(r_mem[c][{r_front, w_ridx}]);
   end

   always_comb begin
      case (r_addr[13:0])
         14'h0:   w_reg = BUS_W'({r_overrun, r_lock, r_ready});
         14'h1:   w_reg = BUS_W'({r_arm, r_mode, r_lock});
         14'h2:   w_reg = BUS_W'(r_pre);
         14'h3:   w_reg = BUS_W'(r_tsel);
         14'h4:   w_reg = BUS_W'(r_fcnt);
         default: w_reg = '1;
      endcase
   end
   assign w_rdata = r_addr[14] ? w_reg : w_win;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr <= '0;
         r_dout <= '1;
         r_arm  <= 1'b1;
         r_mode <= 2'b00;
         r_lock <= 1'b0;
         r_pre  <= '0;
         r_tsel <= '0;
      end else if (bus_en) begin
         if (addr_we) r_addr <= bus_din;
         if (reg_we && r_addr[14]) begin
            case (r_addr[13:0])
               14'h1: {r_arm, r_mode, r_lock} <= bus_din[3:0];
               14'h2: r_pre  <= bus_din[AW-1:0];
               14'h3: r_tsel <= bus_din[1:0];
               default: ;
            endcase
         end
         if (rd_req) r_dout <= w_rdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_front     <= 1'b0;
         r_start     <= '0;
         r_wptr      <= '0;
         r_cnt       <= '0;
         r_ready     <= 1'b0;
         r_overrun   <= 1'b0;
         r_fcnt      <= '0;
         r_trig_prev <= 1'b0;
      end else begin
         if (sample_stb) r_trig_prev <= w_trig_cur;
         case (r_state)
            S_IDLE: begin
               r_cnt <= '0;
               if (r_arm && stable) r_state <= (r_pre == '0) ? S_WAIT : S_ARMED;
            end
            S_ARMED: begin
               if (!stable) r_state <= S_IDLE;
               else if (sample_stb) begin
                  r_wptr <= r_wptr + AW'(1);
                  r_cnt  <= w_cnt_inc;
                  if (w_cnt_inc == {1'b0, r_pre}) begin
                     r_cnt   <= '0;
                     r_state <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (!stable) r_state <= S_IDLE;
               else if (sample_stb) begin
                  r_wptr <= r_wptr + AW'(1);
                  if (w_trig) begin
                     r_cnt   <= PW'(1);
                     r_state <= (w_post_len == PW'(1)) ? S_SWAP : S_POST;
                  end
               end
            end
            S_POST: begin
               if (!stable) r_state <= S_IDLE;
               else if (sample_stb) begin
                  r_wptr <= r_wptr + AW'(1);
                  r_cnt  <= w_cnt_inc;
                  if (w_cnt_inc == w_post_len) r_state <= S_SWAP;
               end
            end
            S_SWAP: begin
               if (!w_lock_block) begin
                  r_front <= ~r_front;
                  r_start <= r_wptr;
                  r_ready <= 1'b1;
                  r_fcnt  <= r_fcnt + 16'd1;
                  r_state <= S_IDLE;
               end else
                  r_overrun <= 1'b1;
            end
            default: r_state <= S_IDLE;
         endcase
         if (w_lock_rise) begin
            r_ready   <= 1'b0;
            r_overrun <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int c = 0; c < CH_NUM; c++)
         if (w_cap) r_mem[c][{~r_front, r_wptr}] <= adc_data[c*ADC_W +: ADC_W];
   end

   assign bus_dout    = r_dout;
   assign frame_ready = r_ready;

endmodule

// File: tb/tb_multi_dual_buffer.sv
// Directed bench for multi_dual_buffer: CH_NUM=2, DEPTH=16, hand-computed frame contents.
module tb_multi_dual_buffer;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        bus_en = 1'b0, addr_we = 1'b0, reg_we = 1'b0, rd_req = 1'b0;
   logic [15:0] bus_din = '0, bus_dout;
   logic        sample_stb = 1'b0, stable = 1'b0, frame_ready;
   logic [23:0] adc_data = '0;
   logic [1:0]  trig_in = '0;
   int          n_chk = 0, n_err = 0;

   multi_dual_buffer #(.BUS_W(16), .ADC_W(12), .CH_NUM(2), .DEPTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .bus_en(bus_en), .addr_we(addr_we), .reg_we(reg_we),
      .rd_req(rd_req), .bus_din(bus_din), .bus_dout(bus_dout), .sample_stb(sample_stb),
      .adc_data(adc_data), .trig_in(trig_in), .stable(stable), .frame_ready(frame_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_addr(input logic [15:0] a);
      bus_en = 1'b1; addr_we = 1'b1; bus_din = a;
      tick();
      bus_en = 1'b0; addr_we = 1'b0;
   endtask

   task automatic wr_reg(input logic [15:0] a, input logic [15:0] d);
      wr_addr(a);
      bus_en = 1'b1; reg_we = 1'b1; bus_din = d;
      tick();
      bus_en = 1'b0; reg_we = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [15:0] a, input logic [15:0] exp);
      wr_addr(a);
      bus_en = 1'b1; rd_req = 1'b1;
      tick();
      bus_en = 1'b0; rd_req = 1'b0;
      chk(tag, bus_dout, exp);
   endtask

   // ch0 carries n, ch1 carries n+0x100
   task automatic strobe(input int n, input logic t);
      adc_data = {12'(n + 256), 12'(n)};
      trig_in  = {1'b0, t};
      sample_stb = 1'b1;
      tick();
      sample_stb = 1'b0;
      tick();
   endtask

   initial begin
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      chk("rst_dout", bus_dout, 16'hFFFF);
      chk("rst_ready", 16'(frame_ready), 16'h0);
      rd_chk("rst_status", 16'h4000, 16'h0000);
      rd_chk("rst_ctrl", 16'h4001, 16'h0008);
      rd_chk("rst_fcnt", 16'h4004, 16'h0000);

      // Free-run, PRE=0: 16 samples fill the buffer in order.
      stable = 1'b1;
      tick(); tick();
      for (int n = 0; n < 16; n++) strobe(n, 1'b0);
      chk("fr_ready", 16'(frame_ready), 16'h1);
      rd_chk("fr_fcnt", 16'h4004, 16'd1);
      rd_chk("fr_ch0_o0", 16'h0000, 16'd0);
      rd_chk("fr_ch0_o5", 16'h0005, 16'd5);
      rd_chk("fr_ch0_o15", 16'h000F, 16'd15);
      rd_chk("fr_ch1_o7", 16'h0017, 16'h0107);

      // Rising trigger, PRE=4; restart capture by dropping stable.
      wr_reg(16'h4001, 16'h000A);
      wr_reg(16'h4002, 16'h0004);
      rd_chk("pre_rb", 16'h4002, 16'h0004);
      stable = 1'b0; tick();
      stable = 1'b1; tick();
      for (int n = 30; n < 52; n++) strobe(n, (n >= 40));
      rd_chk("rise_fcnt", 16'h4004, 16'd2);
      rd_chk("rise_o4", 16'h0004, 16'd40);
      rd_chk("rise_o0", 16'h0000, 16'd36);
      rd_chk("rise_o15", 16'h000F, 16'd51);
      rd_chk("rise_ch1_o4", 16'h0014, 16'h0128);

      // Lock during capture: overrun, front kept, swap after unlock.
      wr_reg(16'h4001, 16'h000B);
      chk("lock_ready", 16'(frame_ready), 16'h0);
      rd_chk("lock_status", 16'h4000, 16'h0002);
      for (int n = 60; n < 77; n++) strobe(n, (n >= 65));
      rd_chk("ovr_status", 16'h4000, 16'h0006);
      chk("ovr_ready", 16'(frame_ready), 16'h0);
      rd_chk("ovr_front_o4", 16'h0004, 16'd40);
      rd_chk("ovr_fcnt", 16'h4004, 16'd2);
      wr_reg(16'h4001, 16'h000A);
      chk("unlock_ready0", 16'(frame_ready), 16'h0);
      tick();
      chk("unlock_ready1", 16'(frame_ready), 16'h1);
      rd_chk("unlock_status", 16'h4000, 16'h0005);
      rd_chk("unlock_o4", 16'h0004, 16'd65);
      rd_chk("unlock_o0", 16'h0000, 16'd61);
      rd_chk("unlock_o15", 16'h000F, 16'd76);
      rd_chk("unlock_fcnt", 16'h4004, 16'd3);

      // Clear ready via lock pulse, then abort a frame mid-POST.
      wr_reg(16'h4001, 16'h000B);
      wr_reg(16'h4001, 16'h000A);
      rd_chk("clr_status", 16'h4000, 16'h0000);
      for (int n = 80; n < 91; n++) strobe(n, (n >= 85));
      stable = 1'b0; tick();
      stable = 1'b1; tick();
      for (int n = 91; n < 111; n++) strobe(n, 1'b1);
      chk("abort_ready", 16'(frame_ready), 16'h0);
      rd_chk("abort_fcnt", 16'h4004, 16'd3);
      rd_chk("abort_o4", 16'h0004, 16'd65);

      // Unmapped channel / register and simultaneous address+data write.
      rd_chk("ch3", 16'h0030, 16'hFFFF);
      rd_chk("ch2", 16'h0025, 16'hFFFF);
      rd_chk("reg7", 16'h4007, 16'hFFFF);
      wr_addr(16'h4002);
      bus_en = 1'b1; addr_we = 1'b1; reg_we = 1'b1; bus_din = 16'h4003;
      tick();
      bus_en = 1'b0; addr_we = 1'b0; reg_we = 1'b0;
      rd_chk("both_pre", 16'h4002, 16'h0003);
      rd_chk("both_tsel", 16'h4003, 16'h0000);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
